// File: rtl/framing.sv
// -----------------------------------------------------------------------------
// framing
//   Cuts a mono PCM sample stream into overlapping analysis frames of
//   FRAME_LEN samples that advance by HOP samples. Frames are emitted back to
//   back on a single one-sample-per-cycle stream (frame 0, frame 1, ...).
//   Incoming samples land in a FRAME_LEN-deep circular buffer. Sample w sits at
//   address w mod FRAME_LEN. The reader walks s = f*HOP + j and stalls whenever
//   s has not arrived yet.
//
// Ports
//   clk      in   1            rising-edge clock
//   rst      in   1            synchronous reset, active-high
//   data_i   in   I_BW signed  input sample
//   di_en    in   2            1 = sample valid, 2 = wait slot, 0/3 = invalid
//   in_num   in   IN_NUM_W     upstream slot counter (not used by the logic)
//   data_o   out  O_BW signed  frame sample, sign-extended
//   do_en    out  1            data_o/out_num valid this cycle
//   out_num  out  OUT_NUM_W    global output sample index
// -----------------------------------------------------------------------------
module framing #(
  parameter  int TOTAL_DATA = 15104,
  parameter  int I_BW       = 14,
  parameter  int O_BW       = 14,
  parameter  int FRAME_LEN  = 1024,
  parameter  int HOP        = 160,
  localparam int N_FRAMES   = (TOTAL_DATA - FRAME_LEN) / HOP + 1,
  localparam int OUT_TOTAL  = N_FRAMES * FRAME_LEN,
  localparam int IN_NUM_W   = $clog2(TOTAL_DATA),
  localparam int OUT_NUM_W  = $clog2(OUT_TOTAL)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [I_BW-1:0]      data_i,
  input  logic        [1:0]           di_en,
  input  logic        [IN_NUM_W-1:0]  in_num,
  output logic signed [O_BW-1:0]      data_o,
  output logic                        do_en,
  output logic        [OUT_NUM_W-1:0] out_num
);

  localparam int AW   = $clog2(FRAME_LEN);
  localparam int WC_W = $clog2(TOTAL_DATA + 1);
  localparam int OC_W = $clog2(OUT_TOTAL + 1);
  localparam int F_W  = $clog2(N_FRAMES + 1);
  // Sample index width: big enough for f*HOP+j with no modular wrap, and for
  // wr_cnt, so that both can be compared directly.
  localparam int S_W  = $clog2(TOTAL_DATA + N_FRAMES * HOP + FRAME_LEN + 1);

  logic        [I_BW-1:0]      buf_mem [FRAME_LEN];

  logic        [WC_W-1:0]      wr_cnt_q,  wr_cnt_d;
  logic        [OC_W-1:0]      out_cnt_q, out_cnt_d;
  logic        [F_W-1:0]       frm_q,     frm_d;
  logic        [AW-1:0]        ofs_q,     ofs_d;
  logic signed [O_BW-1:0]      data_o_q,  data_o_d;
  logic                        do_en_q,   do_en_d;
  logic        [OUT_NUM_W-1:0] out_num_q, out_num_d;

  logic                        wr_en_s;
  logic        [S_W-1:0]       rd_idx_s;
  logic        [S_W-1:0]       wr_idx_s;
  logic                        avail_s;
  logic                        fire_s;
  logic signed [I_BW-1:0]      rd_data_s;

  // The upstream slot counter is informational only.
  logic unused_in_num_s;
  assign unused_in_num_s = ^in_num;

  // Write qualification and read target / availability.
  always_comb begin
    wr_en_s  = 1'b0;
    rd_idx_s = S_W'(frm_q) * S_W'(HOP) + S_W'(ofs_q);
    wr_idx_s = S_W'(wr_cnt_q);
    avail_s  = 1'b0;
    fire_s   = 1'b0;
    if ((di_en == 2'd1) && (wr_cnt_q < WC_W'(TOTAL_DATA))) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    // A sample is readable once stored, or in the very cycle it is written.
    if ((rd_idx_s < wr_idx_s) || ((rd_idx_s == wr_idx_s) && wr_en_s)) begin
      avail_s = 1'b1;
    end else begin
      avail_s = 1'b0;
    end
    if (avail_s && (out_cnt_q < OC_W'(OUT_TOTAL))) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
  end

  // Read data select: forward data_i when the target is being written now.
  // Otherwise the buffer holds it. The pacing contract keeps the write address
  // away from the read address in that case.
  always_comb begin
    rd_data_s = '0;
    if (rd_idx_s == wr_idx_s) begin
      rd_data_s = data_i;
    end else begin
      rd_data_s = buf_mem[rd_idx_s[AW-1:0]];
    end
  end

  // Next-state computation for counters, read position and the output stage.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    out_cnt_d = out_cnt_q;
    frm_d     = frm_q;
    ofs_d     = ofs_q;
    data_o_d  = data_o_q;
    do_en_d   = 1'b0;
    out_num_d = out_num_q;
    if (wr_en_s) begin
      wr_cnt_d = wr_cnt_q + WC_W'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (fire_s) begin
      data_o_d  = O_BW'(rd_data_s);  // signed source, so this sign-extends
      do_en_d   = 1'b1;
      out_num_d = out_cnt_q[OUT_NUM_W-1:0];
      out_cnt_d = out_cnt_q + OC_W'(1);
      if (ofs_q == AW'(FRAME_LEN - 1)) begin
        ofs_d = '0;
        frm_d = frm_q + F_W'(1);
      end else begin
        ofs_d = ofs_q + AW'(1);
        frm_d = frm_q;
      end
    end else begin
      // Stall: data_o and out_num hold their values and do_en drops.
      data_o_d  = data_o_q;
      do_en_d   = 1'b0;
      out_num_d = out_num_q;
      out_cnt_d = out_cnt_q;
      ofs_d     = ofs_q;
      frm_d     = frm_q;
    end
  end

  // Circular sample buffer. Its contents are meaningless after reset because
  // wr_cnt restarts at zero.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_mem[wr_cnt_q[AW-1:0]] <= data_i;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      out_cnt_q <= '0;
      frm_q     <= '0;
      ofs_q     <= '0;
      data_o_q  <= '0;
      do_en_q   <= 1'b0;
      out_num_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      out_cnt_q <= out_cnt_d;
      frm_q     <= frm_d;
      ofs_q     <= ofs_d;
      data_o_q  <= data_o_d;
      do_en_q   <= do_en_d;
      out_num_q <= out_num_d;
    end
  end

  assign data_o  = data_o_q;
  assign do_en   = do_en_q;
  assign out_num = out_num_q;

endmodule

// File: tb/tb_framing.sv
// -----------------------------------------------------------------------------
// tb_framing
//   Self-checking bench for framing. The geometry is scaled down
//   (FRAME_LEN=64, HOP=10, TOTAL_DATA=944 -> 89 frames), so every full
//   utterance stays short. The output is widened to 16 bits to exercise sign
//   extension. Expected outputs come from a reference model built from
//   counts: output k belongs to frame k/FRAME_LEN at offset k%FRAME_LEN. It
//   may appear only once that sample has been accepted.
// -----------------------------------------------------------------------------
module tb_framing;

  localparam int TD  = 944;
  localparam int IBW = 14;
  localparam int OBW = 16;
  localparam int FL  = 64;
  localparam int HP  = 10;
  localparam int NF  = (TD - FL) / HP + 1;
  localparam int OT  = NF * FL;
  localparam int INW = $clog2(TD);
  localparam int ONW = $clog2(OT);

  logic                  clk;
  logic                  rst;
  logic signed [IBW-1:0] data_i;
  logic        [1:0]     di_en;
  logic        [INW-1:0] in_num;
  logic signed [OBW-1:0] data_o;
  logic                  do_en;
  logic        [ONW-1:0] out_num;

  framing #(
    .TOTAL_DATA(TD),
    .I_BW      (IBW),
    .O_BW      (OBW),
    .FRAME_LEN (FL),
    .HOP       (HP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .di_en  (di_en),
    .in_num (in_num),
    .data_o (data_o),
    .do_en  (do_en),
    .out_num(out_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog, far above the expected run length.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int             sent [TD];
  int             n_acc;
  int             k_out;
  logic [OBW-1:0] last_d;
  logic [ONW-1:0] last_n;

  // Run bookkeeping.
  int cyc = 0;
  int first_hi, last_hi, hi_cnt;
  int obs [OT];
  bit stop;
  int w;

  function automatic int rnd_sample();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  // One clock: drive inputs, predict, clock, compare.
  task automatic step(input logic r, input logic [1:0] en, input int v);
    logic           e_en;
    logic [OBW-1:0] e_d;
    logic [ONW-1:0] e_n;
    bit             acc;
    bit             avail;
    int             s;
    int             tmp;
    rst    = r;
    di_en  = en;
    data_i = v[IBW-1:0];
    in_num = INW'($urandom_range(0, TD - 1));
    if (r) begin
      n_acc  = 0;
      k_out  = 0;
      last_d = '0;
      last_n = '0;
      e_en   = 1'b0;
    end else begin
      acc   = (en == 2'd1) && (n_acc < TD);
      avail = 1'b0;
      s     = 0;
      if (k_out < OT) begin
        s     = (k_out / FL) * HP + (k_out % FL);
        avail = (s < n_acc) || ((s == n_acc) && acc);
      end
      if (acc) begin
        sent[n_acc] = v;
        n_acc++;
      end
      if (avail) begin
        tmp    = sent[s];
        last_d = tmp[OBW-1:0];
        last_n = k_out[ONW-1:0];
        k_out++;
        e_en   = 1'b1;
      end else begin
        e_en   = 1'b0;
      end
    end
    e_d = last_d;
    e_n = last_n;
    @(posedge clk);
    #1;
    cyc++;
    tests++;
    if (do_en !== e_en || data_o !== e_d || out_num !== e_n) begin
      fails++;
      $display("FAIL stream cyc=%0d: do_en/data_o/out_num = %0b/%h/%0d, required %0b/%h/%0d",
               cyc, do_en, data_o, out_num, e_en, e_d, e_n);
    end
    if (do_en === 1'b1) begin
      if (first_hi < 0) first_hi = cyc;
      last_hi = cyc;
      hi_cnt++;
      if (int'(out_num) < OT) obs[out_num] = int'(data_o);
    end
  endtask

  task automatic chk_abort(input int abort_at);
    if (abort_at > 0 && k_out >= abort_at) stop = 1'b1;
  endtask

  task automatic send(input bit idx_mode, input int abort_at);
    int v;
    v = idx_mode ? w : rnd_sample();
    step(1'b0, 2'd1, v);
    w++;
    chk_abort(abort_at);
  endtask

  task automatic idle(input bit idx_mode, input int abort_at);
    int r;
    logic [1:0] code;
    r = int'($urandom_range(0, 2));
    if (idx_mode)    code = 2'd2;
    else if (r == 0) code = 2'd0;
    else if (r == 1) code = 2'd2;
    else             code = 2'd3;
    step(1'b0, code, rnd_sample());
    chk_abort(abort_at);
  endtask

  // One utterance under the pacing contract, with optional extra wait slots
  // per burst and an optional early stop after abort_at outputs.
  task automatic run(input bit idx_mode, input int fixed_extra, input int max_rand_extra,
                     input int abort_at);
    int extra;
    int budget;
    stop     = 1'b0;
    w        = 0;
    first_hi = -1;
    last_hi  = -1;
    hi_cnt   = 0;
    step(1'b1, 2'd1, 0);
    step(1'b1, 2'd1, 0);
    first_hi = -1;
    last_hi  = -1;
    hi_cnt   = 0;
    for (int i = 0; i < FL && !stop; i++) send(idx_mode, abort_at);
    while (w < TD && !stop) begin
      for (int i = 0; i < HP && w < TD && !stop; i++) send(idx_mode, abort_at);
      extra = fixed_extra;
      if (max_rand_extra > 0) extra = extra + int'($urandom_range(0, max_rand_extra));
      for (int i = 0; i < FL - HP + extra && !stop; i++) idle(idx_mode, abort_at);
    end
    budget = 0;
    while (k_out < OT && !stop && budget < 4 * OT) begin
      idle(idx_mode, abort_at);
      budget++;
    end
    if (!stop) begin
      tests++;
      if (k_out != OT) begin
        fails++;
        $display("FAIL run_timeout: outputs %0d, required %0d", k_out, OT);
      end
      // Samples beyond the utterance are ignored and no more output appears.
      for (int i = 0; i < 8; i++) step(1'b0, 2'd1, rnd_sample());
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  typedef struct {
    logic           r;
    logic [1:0]     en;
    int             v;
    logic           x_en;
    logic [OBW-1:0] x_d;
    logic [ONW-1:0] x_n;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 2'd1, 5,     1'b0, 16'h0000, ONW'(0)};
    tbl[1]  = '{1'b1, 2'd1, 6,     1'b0, 16'h0000, ONW'(0)};
    tbl[2]  = '{1'b1, 2'd1, 7,     1'b0, 16'h0000, ONW'(0)};
    tbl[3]  = '{1'b0, 2'd0, 9,     1'b0, 16'h0000, ONW'(0)};
    tbl[4]  = '{1'b0, 2'd3, 9,     1'b0, 16'h0000, ONW'(0)};
    tbl[5]  = '{1'b0, 2'd2, 9,     1'b0, 16'h0000, ONW'(0)};
    tbl[6]  = '{1'b0, 2'd1, -8192, 1'b1, 16'hE000, ONW'(0)};
    tbl[7]  = '{1'b0, 2'd1, 100,   1'b1, 16'h0064, ONW'(1)};
    tbl[8]  = '{1'b0, 2'd0, 1,     1'b0, 16'h0064, ONW'(1)};
    tbl[9]  = '{1'b0, 2'd1, 8191,  1'b1, 16'h1FFF, ONW'(2)};
    tbl[10] = '{1'b1, 2'd1, 3,     1'b0, 16'h0000, ONW'(0)};
    tbl[11] = '{1'b0, 2'd1, 42,    1'b1, 16'h002A, ONW'(0)};

    rst    = 1'b1;
    di_en  = 2'd0;
    data_i = '0;
    in_num = '0;

    // Table vectors: reset, invalid codes, forwarding, hold, sign extension.
    for (int i = 0; i < 12; i++) begin
      rst    = tbl[i].r;
      di_en  = tbl[i].en;
      data_i = tbl[i].v[IBW-1:0];
      @(posedge clk);
      #1;
      tests++;
      if (do_en !== tbl[i].x_en || data_o !== tbl[i].x_d || out_num !== tbl[i].x_n) begin
        fails++;
        $display("FAIL vec%0d: do_en/data_o/out_num = %0b/%h/%0d, required %0b/%h/%0d",
                 i, do_en, data_o, out_num, tbl[i].x_en, tbl[i].x_d, tbl[i].x_n);
      end
    end

    // Nominal pacing with data = sample index.
    for (int i = 0; i < OT; i++) obs[i] = -1;
    run(1'b1, 0, 0, 0);
    check_int("frame1_first",      obs[FL],              HP);
    check_int("frame1_last_old",   obs[FL + FL - HP - 1], FL - 1);
    check_int("frame1_first_new",  obs[FL + FL - HP],     FL);
    check_int("frame1_last",       obs[2 * FL - 1],       FL + HP - 1);
    check_int("last_output",       obs[OT - 1],           TD - 1);
    check_int("continuous_count",  hi_cnt,                OT);
    check_int("continuous_span",   last_hi - first_hi + 1, OT);

    // Bursts delayed by 5 extra wait slots: stalls appear, stream stays exact.
    run(1'b1, 5, 0, 0);
    check_int("delayed_count", hi_cnt, OT);
    tests++;
    if (last_hi - first_hi + 1 <= OT) begin
      fails++;
      $display("FAIL delayed_stall: output span %0d, required more than %0d",
               last_hi - first_hi + 1, OT);
    end

    // Random data, random extra delays and mixed wait codes.
    run(1'b0, 0, 5, 0);

    // Reset in the middle of an utterance, then a clean restart.
    run(1'b0, 0, 2, 500);
    step(1'b1, 2'd1, rnd_sample());
    step(1'b0, 2'd2, rnd_sample());
    run(1'b0, 0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
